// File: rtl/bit_clk_recovery_p.sv
// bit_clk_recovery_p
// Recovers a bit clock from an asynchronous serial stream in the base-clock
// domain. The bit period is learned from the shortest edge-to-edge interval
// and slowly relaxed upward. A phase counter is realigned to data edges and
// drives the recovered clock and mid-bit sampling.
//
// Ports:
//   clk                 base clock
//   rst_n               asynchronous active-low reset
//   signal_in           asynchronous serial data
//   invert_pulse        debounced level, each 1->0 transition flips clk_rec
//   period_override_en  force the period and stop learning
//   period_override     forced period value (clamped to MIN_PERIOD)
//   clk_rec             recovered bit clock
//   data_out            bit sampled at mid-bit
//   data_valid          one-cycle strobe when data_out updates
//   period              current period estimate in clk cycles
//   locked              period stable and signal present
module bit_clk_recovery_p #(
    parameter int CNT_W           = 16,
    parameter int INIT_PERIOD     = 801,
    parameter int MIN_PERIOD      = 4,
    parameter int RELAX_EDGES     = 15,
    parameter int LOCK_EDGES      = 8,
    parameter int PHASE_WIN_SHIFT = 3,
    parameter int LOS_MULT_SHIFT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             signal_in,
    input  logic             invert_pulse,
    input  logic             period_override_en,
    input  logic [CNT_W-1:0] period_override,
    output logic             clk_rec,
    output logic             data_out,
    output logic             data_valid,
    output logic [CNT_W-1:0] period,
    output logic             locked
);

    localparam int RLX_W = $clog2(RELAX_EDGES + 1);
    localparam int LCK_W = $clog2(LOCK_EDGES + 1);
    localparam int LOS_W = CNT_W + LOS_MULT_SHIFT;

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_P      = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] INIT_P     = CNT_W'(INIT_PERIOD);
    localparam logic [RLX_W-1:0] RLX_ONE    = RLX_W'(1);
    localparam logic [RLX_W-1:0] RELAX_LAST = RLX_W'(RELAX_EDGES - 1);
    localparam logic [LCK_W-1:0] LCK_ONE    = LCK_W'(1);
    localparam logic [LCK_W-1:0] LOCK_TC    = LCK_W'(LOCK_EDGES);
    localparam logic [LCK_W-1:0] LOCK_LAST  = LCK_W'(LOCK_EDGES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] interval_q, interval_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [RLX_W-1:0] relax_cnt_q, relax_cnt_d;
    logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             locked_q, locked_d;
    logic             inv_q, inv_d;
    logic             inv_prev_q, inv_prev_d;
    logic             clk_rec_q, clk_rec_d;
    logic             data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;

    logic             edge_det;
    logic             valid_edge;
    logic             in_window;
    logic             los_hit;
    logic             big_shrink;
    logic [CNT_W-1:0] win;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] period_m1;
    logic [CNT_W-1:0] shrink_amt;
    logic [LOS_W-1:0] los_lim;
    logic [LOS_W-1:0] interval_ext;

    assign edge_det     = sync2_q ^ prev_q;
    assign valid_edge   = edge_det && (interval_q >= MIN_P);
    assign win          = period_q >> PHASE_WIN_SHIFT;
    assign half         = period_q >> 1;
    assign period_m1    = period_q - CNT_ONE;
    // Edges close to either end of the phase cycle pull the phase back to 0;
    // edges near mid-bit are treated as noise and ignored for alignment.
    assign in_window    = (phase_q < win) || (phase_q > (period_m1 - win));
    // Widened so the LOS threshold cannot wrap for large periods.
    assign los_lim      = {{LOS_MULT_SHIFT{1'b0}}, period_q} << LOS_MULT_SHIFT;
    assign interval_ext = {{LOS_MULT_SHIFT{1'b0}}, interval_q};
    // An edge in the same cycle always beats loss-of-signal.
    assign los_hit      = !edge_det && (interval_ext >= los_lim);
    assign shrink_amt   = period_q - interval_q;
    assign big_shrink   = shrink_amt > (period_q >> 3);

    always_comb begin
        sync1_d      = signal_in;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        interval_d   = interval_q;
        phase_d      = phase_q;
        period_d     = period_q;
        relax_cnt_d  = relax_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        locked_d     = locked_q;
        inv_d        = inv_q;
        inv_prev_d   = invert_pulse;
        clk_rec_d    = (phase_q >= half) ^ inv_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;

        if (edge_det) begin
            interval_d = CNT_ONE;
        end else if (interval_q != CNT_MAX) begin
            interval_d = interval_q + CNT_ONE;
        end

        // The >= also catches a phase left stranded above a freshly shrunk period.
        if (valid_edge && in_window) begin
            phase_d = '0;
        end else if (phase_q >= period_m1) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + CNT_ONE;
        end

        if (phase_q == half) begin
            data_out_d   = sync2_q;
            data_valid_d = 1'b1;
        end

        if (inv_prev_q && !invert_pulse) begin
            inv_d = ~inv_q;
        end

        if (period_override_en) begin
            period_d = (period_override < MIN_P) ? MIN_P : period_override;
            if (los_hit) begin
                locked_d   = 1'b0;
                lock_cnt_d = '0;
            end
        end else if (valid_edge) begin
            if (interval_q < period_q) begin
                period_d    = interval_q;
                relax_cnt_d = '0;
                if (big_shrink) begin
                    lock_cnt_d = '0;
                    locked_d   = 1'b0;
                end
            end else begin
                if (relax_cnt_q == RELAX_LAST) begin
                    relax_cnt_d = '0;
                    if (period_q != CNT_MAX) begin
                        period_d = period_q + CNT_ONE;
                    end
                end else begin
                    relax_cnt_d = relax_cnt_q + RLX_ONE;
                end
                if (lock_cnt_q != LOCK_TC) begin
                    lock_cnt_d = lock_cnt_q + LCK_ONE;
                end
                if (lock_cnt_q >= LOCK_LAST) begin
                    locked_d = 1'b1;
                end
            end
        end else if (los_hit) begin
            locked_d   = 1'b0;
            lock_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            interval_q   <= '0;
            phase_q      <= '0;
            period_q     <= INIT_P;
            relax_cnt_q  <= '0;
            lock_cnt_q   <= '0;
            locked_q     <= 1'b0;
            inv_q        <= 1'b0;
            inv_prev_q   <= 1'b1;
            clk_rec_q    <= 1'b0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            interval_q   <= interval_d;
            phase_q      <= phase_d;
            period_q     <= period_d;
            relax_cnt_q  <= relax_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            locked_q     <= locked_d;
            inv_q        <= inv_d;
            inv_prev_q   <= inv_prev_d;
            clk_rec_q    <= clk_rec_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign clk_rec    = clk_rec_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign period     = period_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_bit_clk_recovery_p.sv
// tb_bit_clk_recovery_p
// Directed bench for bit_clk_recovery_p. A cycle-level behavioural model
// (sample history, edge timestamps, integer period arithmetic) is checked
// against every output on each falling clock edge, and literal expectations
// pin key points of each scenario.
module tb_bit_clk_recovery_p;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        signal_in = 1'b0;
    logic        invert_pulse = 1'b1;
    logic        period_override_en = 1'b0;
    logic [15:0] period_override = 16'd0;
    logic        clk_rec;
    logic        data_out;
    logic        data_valid;
    logic [15:0] period;
    logic        locked;

    int checks = 0;
    int passes = 0;

    bit_clk_recovery_p dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .signal_in          (signal_in),
        .invert_pulse       (invert_pulse),
        .period_override_en (period_override_en),
        .period_override    (period_override),
        .clk_rec            (clk_rec),
        .data_out           (data_out),
        .data_valid         (data_valid),
        .period             (period),
        .locked             (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act >= lo && act <= hi) passes++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // ---------------- behavioural model ----------------
    int m_k, m_last, m_per, m_relax, m_lock, m_ph;
    bit m_locked, m_inv, m_inv_prev, m_clk, m_dout, m_dv;
    bit hist[$];

    task automatic model_reset();
        m_k = 0; m_last = 1; m_per = 801; m_relax = 0; m_lock = 0; m_ph = 0;
        m_locked = 0; m_inv = 0; m_inv_prev = 1; m_clk = 0; m_dout = 0; m_dv = 0;
        hist = {1'b0, 1'b0, 1'b0};
    endtask

    task automatic model_step();
        int iv, w, half, n_ph;
        bit s, p, edge_seen, valid, los;
        m_k++;
        s = hist[1];
        p = hist[2];
        edge_seen = (s != p);
        iv = m_k - m_last;
        if (iv > 65535) iv = 65535;
        valid = edge_seen && (iv >= 4);
        los = !edge_seen && (iv >= m_per * 16);
        w = m_per / 8;
        half = m_per / 2;
        m_clk = (m_ph >= half) ^ m_inv;
        m_dv = (m_ph == half);
        if (m_dv) m_dout = s;
        if (valid && (m_ph < w || m_ph > m_per - 1 - w)) n_ph = 0;
        else if (m_ph + 1 >= m_per) n_ph = 0;
        else n_ph = m_ph + 1;
        if (period_override_en) begin
            if (los) begin m_locked = 0; m_lock = 0; end
            m_per = (period_override < 16'd4) ? 4 : int'(period_override);
        end else if (valid) begin
            if (iv < m_per) begin
                if (m_per - iv > m_per / 8) begin m_lock = 0; m_locked = 0; end
                m_per = iv;
                m_relax = 0;
            end else begin
                m_relax++;
                if (m_relax == 15) begin
                    m_relax = 0;
                    if (m_per < 65535) m_per++;
                end
                if (m_lock < 8) m_lock++;
                if (m_lock == 8) m_locked = 1;
            end
        end else if (los) begin
            m_locked = 0;
            m_lock = 0;
        end
        m_ph = n_ph;
        if (m_inv_prev && !invert_pulse) m_inv = !m_inv;
        m_inv_prev = invert_pulse;
        hist.push_front(signal_in);
        void'(hist.pop_back());
        if (edge_seen) m_last = m_k;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("clk_rec", clk_rec, m_clk);
                chk("data_out", data_out, m_dout);
                chk("data_valid", data_valid, m_dv);
                chk("period", period, m_per);
                chk("locked", locked, m_locked);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic toggle_after(input int gap);
        wait_neg(gap);
        signal_in = ~signal_in;
    endtask

    task automatic toggles(input int n, input int gap);
        for (int i = 0; i < n; i++) toggle_after(gap);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_clk_rec"}, clk_rec, 0);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_data_valid"}, data_valid, 0);
        chk({tag, "_period"}, period, 801);
        chk({tag, "_locked"}, locked, 0);
    endtask

    initial begin
        int cnt;
        // reset state
        wait_neg(2);
        #1 check_reset_values("reset");
        wait_neg(2);
        rst_n = 1'b1;

        // 1: learn 20-cycle bit period and lock
        toggles(2, 20);
        wait_neg(5);
        chk("t1_period_2nd_edge", period, 20);
        chk("t1_unlocked_2nd_edge", locked, 0);
        toggle_after(15);
        toggles(11, 20);
        wait_neg(5);
        chk("t1_locked", locked, 1);
        chk_rng("t1_period", period, 20, 21);

        // 2: 2-clk glitch right after a real edge
        toggle_after(15);
        wait_neg(1);
        signal_in = ~signal_in;
        wait_neg(2);
        signal_in = ~signal_in;
        toggle_after(20);
        toggles(5, 20);
        wait_neg(5);
        chk_rng("t2_period_after_glitch", period, 20, 21);
        chk("t2_locked_after_glitch", locked, 1);

        // 3: one 19-cycle interval, then relax back to 20
        toggle_after(14);
        wait_neg(5);
        chk("t3_period_shrunk", period, 19);
        toggle_after(15);
        toggles(13, 20);
        wait_neg(5);
        chk("t3_period_14_edges", period, 19);
        toggle_after(15);
        wait_neg(5);
        chk("t3_period_relaxed", period, 20);
        chk("t3_locked", locked, 1);

        // 4: loss of signal
        wait_neg(300);
        chk("t4_locked_before_los", locked, 1);
        wait_neg(25);
        chk("t4_locked_after_los", locked, 0);
        chk("t4_period_held", period, 20);

        // 5: async reset mid-operation, then override clamp and relax from override
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        period_override = 16'd2;
        period_override_en = 1'b1;
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(4);
        chk("t5_override_clamped", period, 4);
        wait_neg(20);
        period_override_en = 1'b0;
        wait_neg(3);
        chk("t5_period_after_release", period, 4);
        toggles(29, 50);
        wait_neg(5);
        chk("t5_period_29_edges", period, 5);
        toggle_after(45);
        wait_neg(5);
        chk("t5_period_30_edges", period, 6);
        chk("t5_locked", locked, 1);

        // 6: output phase inversion
        @(negedge clk);
        #1 rst_n = 1'b0;
        wait_neg(2);
        rst_n = 1'b1;
        toggles(14, 20);
        fork
            toggles(12, 20);
            begin
                cnt = 0;
                repeat (100) begin
                    @(negedge clk);
                    if (data_valid) cnt++;
                end
                chk("t6_dv_before_invert", cnt, 5);
                invert_pulse = 1'b0;
                cnt = 0;
                repeat (100) begin
                    @(negedge clk);
                    if (data_valid) cnt++;
                end
                chk("t6_dv_while_inverted", cnt, 5);
                invert_pulse = 1'b1;
                wait_neg(10);
                invert_pulse = 1'b0;
            end
        join
        wait_neg(5);
        chk("t6_locked", locked, 1);
        chk_rng("t6_period", period, 20, 21);
        wait_neg(40);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
